// File: rtl/sipo_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_deserializer_pkg
//  Purpose  : Shared types and constants for the SIPO deserializer slice.
//             - fill_state_t : word-fill FSM encoding (S_IDLE / S_FILL)
//             - C_DEFAULT_WIDTH : default word width in bits
//  Revision : 1.0  initial release
// ============================================================================
package sipo_deserializer_pkg;

    localparam int C_DEFAULT_WIDTH = 8;

    // Fill FSM: IDLE while no bits of the current word have arrived,
    // FILL while a partial word is being collected.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } fill_state_t;

endpackage : sipo_deserializer_pkg
`default_nettype wire

// File: rtl/sipo_deserializer_dff_sr.sv
`default_nettype none
// ============================================================================
//  Module   : dff_sr
//  Purpose  : One-bit rising-edge D flip-flop with synchronous active-high
//             reset. Storage primitive for every state bit of the deserializer.
//  Ports    : Q (out) stored bit, C (in) clock, R (in) sync reset, D (in) data
//  Revision : 1.0  initial release
// ============================================================================
module dff_sr (
    output logic Q,
    input  logic C,
    input  logic R,
    input  logic D
);

    always_ff @(posedge C) begin
        if (R) begin
            Q <= 1'b0;
        end else begin
            Q <= D;
        end
    end

endmodule : dff_sr
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_deserializer
//  Purpose  : Serial-in/parallel-out deserializer. Collects WIDTH serial bits
//             into a word and presents it on a holding register (PQ/PV) that
//             keeps the word until the consumer accepts it (PA).
//  Ports    : C   (in)  clock, rising edge
//             R   (in)  synchronous active-high reset
//             SI  (in)  serial data bit
//             SE  (in)  shift enable; SI sampled only when SE=1
//             PA  (in)  consumer accept, meaningful while PV=1
//             PQ  (out) held parallel word
//             PV  (out) PQ holds an unaccepted word
//             OVR (out) sticky overrun (cleared only by R)
//             CNT (out) bits received into the current partial word
//  Revision : 1.0  initial release
// ============================================================================
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH     = C_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     C,
    input  logic                     R,
    input  logic                     SI,
    input  logic                     SE,
    input  logic                     PA,
    output logic [WIDTH-1:0]         PQ,
    output logic                     PV,
    output logic                     OVR,
    output logic [$clog2(WIDTH)-1:0] CNT
);

    localparam int C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

    // Flop outputs
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_pq;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_pv;
    logic               r_ovr;
    logic               r_state;

    // Flop inputs / combinational helpers
    logic [WIDTH-1:0]   w_sr_d;
    logic [WIDTH-1:0]   w_pq_d;
    logic [C_CNT_W-1:0] w_cnt_d;
    logic               w_pv_d;
    logic               w_ovr_d;
    fill_state_t        w_state;
    fill_state_t        w_state_d;
    logic [WIDTH-1:0]   w_word;
    logic               w_last_bit;
    logic               w_complete;

    // ------------------------------------------------------------------
    // Storage: every state bit is a dff_sr instance
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sr
            dff_sr u_sr (.Q(r_sr[gi]), .C(C), .R(R), .D(w_sr_d[gi]));
        end
        for (gi = 0; gi < WIDTH; gi++) begin : g_pq
            dff_sr u_pq (.Q(r_pq[gi]), .C(C), .R(R), .D(w_pq_d[gi]));
        end
        for (gi = 0; gi < C_CNT_W; gi++) begin : g_cnt
            dff_sr u_cnt (.Q(r_cnt[gi]), .C(C), .R(R), .D(w_cnt_d[gi]));
        end
    endgenerate

    dff_sr u_pv    (.Q(r_pv),    .C(C), .R(R), .D(w_pv_d));
    dff_sr u_ovr   (.Q(r_ovr),   .C(C), .R(R), .D(w_ovr_d));
    dff_sr u_state (.Q(r_state), .C(C), .R(R), .D(w_state_d));

    assign w_state = fill_state_t'(r_state);

    // ------------------------------------------------------------------
    // Shift direction: the shifted value including the current SI is also
    // the completed word, so a word is available on the edge of its last bit.
    // ------------------------------------------------------------------
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_word = {r_sr[WIDTH-2:0], SI};
        end else begin : g_lsb_first
            assign w_word = {SI, r_sr[WIDTH-1:1]};
        end
    endgenerate

    assign w_last_bit = (r_cnt == C_CNT_LAST);
    assign w_complete = SE & w_last_bit;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_sr_d    = r_sr;
        w_cnt_d   = r_cnt;
        w_state_d = w_state;
        w_pq_d    = r_pq;
        w_pv_d    = r_pv;
        w_ovr_d   = r_ovr;

        if (SE) begin
            w_sr_d = w_word;
            if (w_last_bit) begin
                w_cnt_d   = '0;
                w_state_d = S_IDLE;
            end else begin
                w_cnt_d   = r_cnt + C_CNT_W'(1);
                w_state_d = S_FILL;
            end
        end

        if (w_complete) begin
            // A held word may be replaced only if it is being accepted on
            // this very edge; otherwise the new word is lost.
            if (!r_pv || PA) begin
                w_pq_d = w_word;
                w_pv_d = 1'b1;
            end else begin
                w_ovr_d = 1'b1;
            end
        end else if (PA && r_pv) begin
            w_pv_d = 1'b0;
        end
    end

    assign PQ  = r_pq;
    assign PV  = r_pv;
    assign OVR = r_ovr;
    assign CNT = r_cnt;

endmodule : sipo_deserializer
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_deserializer
//  Purpose  : Self-checking bench for sipo_deserializer. Two instances share
//             the same stimulus: one MSB-first, one LSB-first. A behavioural
//             model collects bits in a queue and forms words arithmetically.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sipo_deserializer;

    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst, si, se, pa;
    logic [7:0] pq_m, pq_l;
    logic       pv_m, pv_l, ovr_m, ovr_l;
    logic [2:0] cnt_m, cnt_l;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
        .C(clk), .R(rst), .SI(si), .SE(se), .PA(pa),
        .PQ(pq_m), .PV(pv_m), .OVR(ovr_m), .CNT(cnt_m)
    );

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .C(clk), .R(rst), .SI(si), .SE(se), .PA(pa),
        .PQ(pq_l), .PV(pv_l), .OVR(ovr_l), .CNT(cnt_l)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit   m_bits[$];
    logic [7:0] m_pq_m, m_pq_l;
    logic       m_pv, m_ovr;

    // One clock edge with the given inputs, then update the model.
    task automatic step(input bit s_i, input bit s_e, input bit p_a, input bit r);
        int   word_m, word_l;
        bit   complete;
        rst = r; si = s_i; se = s_e; pa = p_a;
        @(posedge clk);
        if (r) begin
            m_bits.delete();
            m_pq_m = 8'h00; m_pq_l = 8'h00; m_pv = 1'b0; m_ovr = 1'b0;
        end else begin
            complete = 1'b0;
            word_m = 0; word_l = 0;
            if (s_e) begin
                m_bits.push_back(s_i);
                if (m_bits.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        word_m += int'(m_bits[i]) * (2 ** (WIDTH - 1 - i));
                        word_l += int'(m_bits[i]) * (2 ** i);
                    end
                    m_bits.delete();
                    complete = 1'b1;
                end
            end
            if (complete) begin
                if (!m_pv || p_a) begin
                    m_pq_m = 8'(word_m); m_pq_l = 8'(word_l); m_pv = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (p_a && m_pv) begin
                m_pv = 1'b0;
            end
        end
        #1;
        rst = 1'b0; pa = 1'b0;
    endtask

    // Send a byte MSB first; PA is asserted only on the final bit's edge.
    task automatic send_byte(input logic [7:0] b, input bit pa_last);
        for (int i = 7; i >= 0; i--) step(b[i], 1'b1, (i == 0) ? pa_last : 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({pq_m, pv_m, ovr_m, cnt_m} !== 13'd0) $display("FAIL reset_msb: got pq=%h pv=%b ovr=%b cnt=%0d, want all 0", pq_m, pv_m, ovr_m, cnt_m);
        else n_pass++;
        n_checks++;
        if ({pq_l, pv_l, ovr_l, cnt_l} !== 13'd0) $display("FAIL reset_lsb: got pq=%h pv=%b ovr=%b cnt=%0d, want all 0", pq_l, pv_l, ovr_l, cnt_l);
        else n_pass++;
    endtask

    task automatic test_bit_order();
        send_byte(8'hA5, 1'b0);
        n_checks++;
        if (pq_m !== 8'hA5 || pv_m !== 1'b1 || cnt_m !== 3'd0) $display("FAIL order_a5_msb: got pq=%h pv=%b cnt=%0d, want a5 1 0", pq_m, pv_m, cnt_m);
        else n_pass++;
        n_checks++;
        if (pq_l !== 8'hA5 || pv_l !== 1'b1) $display("FAIL order_a5_lsb: got pq=%h pv=%b, want a5 1", pq_l, pv_l);
        else n_pass++;
        // Accept with no word completing: PV drops, PQ retained
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (pv_m !== 1'b0 || pq_m !== 8'hA5 || pv_l !== 1'b0) $display("FAIL accept_idle: got pv=%b/%b pq=%h, want 0/0 a5", pv_m, pv_l, pq_m);
        else n_pass++;
        // 1,1,0,0,0,0,0,0
        send_byte(8'hC0, 1'b0);
        n_checks++;
        if (pq_l !== 8'h03 || pq_m !== 8'hC0 || ovr_m !== 1'b0) $display("FAIL order_c0: got lsb=%h msb=%h ovr=%b, want 03 c0 0", pq_l, pq_m, ovr_m);
        else n_pass++;
    endtask

    task automatic test_overrun();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        n_checks++;
        if (pq_m !== 8'h3C || ovr_m !== 1'b1 || pv_m !== 1'b1) $display("FAIL overrun: got pq=%h ovr=%b pv=%b, want 3c 1 1", pq_m, ovr_m, pv_m);
        else n_pass++;
        n_checks++;
        if (pq_l !== m_pq_l || ovr_l !== 1'b1) $display("FAIL overrun_lsb: got pq=%h ovr=%b, want %h 1", pq_l, ovr_l, m_pq_l);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovr_m !== 1'b1 || pv_m !== 1'b0 || pq_m !== 8'h3C) $display("FAIL overrun_sticky: got ovr=%b pv=%b pq=%h, want 1 0 3c", ovr_m, pv_m, pq_m);
        else n_pass++;
    endtask

    task automatic test_accept_on_complete();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h81, 1'b1);
        n_checks++;
        if (pq_m !== 8'h81 || pv_m !== 1'b1 || ovr_m !== 1'b0) $display("FAIL accept_on_complete: got pq=%h pv=%b ovr=%b, want 81 1 0", pq_m, pv_m, ovr_m);
        else n_pass++;
    endtask

    task automatic test_gapped_se();
        logic [7:0] b;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        b = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            step(b[i], 1'b1, 1'b0, 1'b0);
            step(1'($urandom), 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (cnt_m !== 3'((8 - i) % 8)) $display("FAIL gap_cnt_hold: got cnt=%0d, want %0d", cnt_m, (8 - i) % 8);
            else n_pass++;
        end
        n_checks++;
        if (pq_m !== 8'h5A || pv_m !== 1'b1 || pq_l !== 8'h5A) $display("FAIL gap_word: got msb=%h lsb=%h pv=%b, want 5a 5a 1", pq_m, pq_l, pv_m);
        else n_pass++;
    endtask

    task automatic test_reset_midword();
        send_byte(8'h77, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (cnt_m !== 3'd4 || pv_m !== 1'b1 || ovr_m !== 1'b1) $display("FAIL pre_reset: got cnt=%0d pv=%b ovr=%b, want 4 1 1", cnt_m, pv_m, ovr_m);
        else n_pass++;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (cnt_m !== 3'd0 || pv_m !== 1'b0 || ovr_m !== 1'b0 || pq_m !== 8'h00) $display("FAIL mid_reset: got cnt=%0d pv=%b ovr=%b pq=%h, want 0 0 0 00", cnt_m, pv_m, ovr_m, pq_m);
        else n_pass++;
        send_byte(8'hC3, 1'b0);
        n_checks++;
        if (pq_m !== 8'hC3 || pv_m !== 1'b1 || pq_l !== 8'hC3) $display("FAIL post_reset_word: got msb=%h lsb=%h pv=%b, want c3 c3 1", pq_m, pq_l, pv_m);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) == 0), ($urandom_range(99) == 0));
            n_checks++;
            if (pq_m !== m_pq_m || pq_l !== m_pq_l || pv_m !== m_pv || pv_l !== m_pv ||
                ovr_m !== m_ovr || ovr_l !== m_ovr ||
                cnt_m !== 3'(m_bits.size()) || cnt_l !== 3'(m_bits.size())) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got pq=%h/%h pv=%b/%b ovr=%b/%b cnt=%0d/%0d, want pq=%h/%h pv=%b ovr=%b cnt=%0d",
                             k, pq_m, pq_l, pv_m, pv_l, ovr_m, ovr_l, cnt_m, cnt_l,
                             m_pq_m, m_pq_l, m_pv, m_ovr, m_bits.size());
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; si = 1'b0; se = 1'b0; pa = 1'b0;
        m_pq_m = 8'h00; m_pq_l = 8'h00; m_pv = 1'b0; m_ovr = 1'b0;
        @(negedge clk);
        test_reset();
        test_bit_order();
        test_overrun();
        test_accept_on_complete();
        test_gapped_se();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sipo_deserializer
`default_nettype wire
